// File: rtl/alu_pkg.sv
// Shared definitions for the ALU staging stage: opcodes, opcode classes and FSM states.
package alu_pkg;

    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_SUB   = 5'b00001;
    localparam logic [4:0] OP_AND   = 5'b00010;
    localparam logic [4:0] OP_OR    = 5'b00011;
    localparam logic [4:0] OP_XOR   = 5'b00100;
    localparam logic [4:0] OP_NOR   = 5'b00101;
    localparam logic [4:0] OP_ANDN  = 5'b00110;
    localparam logic [4:0] OP_ROR   = 5'b00111;
    localparam logic [4:0] OP_ROL   = 5'b01000;
    localparam logic [4:0] OP_SHR   = 5'b01001;
    localparam logic [4:0] OP_SHRA  = 5'b01010;
    localparam logic [4:0] OP_SHL   = 5'b01011;
    localparam logic [4:0] OP_SLT   = 5'b01100;
    localparam logic [4:0] OP_SLTU  = 5'b01101;
    localparam logic [4:0] OP_PASSB = 5'b01110;
    localparam logic [4:0] OP_MUL   = 5'b01111;
    localparam logic [4:0] OP_DIV   = 5'b10000;

    typedef enum logic [1:0] {
        CLS_SINGLE,
        CLS_MULTI,
        CLS_ILLEGAL
    } op_class_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_e;

    // Rotates and shifts take their amount from operand B.
    function automatic logic is_shift_op(input logic [4:0] op);
        return (op >= OP_ROR) && (op <= OP_SHL);
    endfunction

endpackage

// File: rtl/alu_op_class.sv
// Combinational opcode -> class decoder (single-cycle, multi-cycle, illegal).
module alu_op_class
    import alu_pkg::*;
(
    input  logic [4:0] op_i,
    output op_class_e  cls_o
);

    always_comb begin
        cls_o = CLS_ILLEGAL;
        if (op_i == OP_MUL || op_i == OP_DIV) begin
            cls_o = CLS_MULTI;
        end else if (op_i < OP_MUL) begin
            cls_o = CLS_SINGLE;
        end
    end

endmodule

// File: rtl/alu_stage_ctrl.sv
// Operand staging / result capture around the ALU with a bounded wait for multi-cycle ops.
// Optional build macro ROT_AMOUNT_MASK_EN: reduce shift/rotate amounts modulo 32 before issue.
module alu_stage_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 64
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [4:0]       alu_op,
    output logic             alu_start,
    input  logic             alu_done,
    input  logic [WIDTH-1:0] alu_lo,
    input  logic [WIDTH-1:0] alu_hi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z_lo,
    output logic [WIDTH-1:0] z_hi,
    output logic             err
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_WAIT);

    state_e           state_q, state_d;
    logic [4:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] zlo_q, zlo_d;
    logic [WIDTH-1:0] zhi_q, zhi_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [WIDTH-1:0] b_staged;
    op_class_e        cls;

    alu_op_class u_op_class (
        .op_i  (op_q),
        .cls_o (cls)
    );

`ifdef ROT_AMOUNT_MASK_EN
    assign b_staged = is_shift_op(op) ? {{(WIDTH-5){1'b0}}, b_in[4:0]} : b_in;
`else
    assign b_staged = b_in;
`endif

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        zlo_d     = zlo_q;
        zhi_d     = zhi_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        alu_start = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    op_d    = op;
                    a_d     = a_in;
                    b_d     = b_staged;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                case (cls)
                    CLS_SINGLE: begin
                        alu_start = 1'b1;
                        zlo_d     = alu_lo;
                        zhi_d     = alu_hi;
                        state_d   = S_HOLD;
                    end
                    CLS_MULTI: begin
                        alu_start = 1'b1;
                        if (alu_done) begin
                            zlo_d   = alu_lo;
                            zhi_d   = alu_hi;
                            state_d = S_HOLD;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                    default: begin
                        zlo_d   = '0;
                        zhi_d   = '0;
                        err_d   = 1'b1;
                        state_d = S_HOLD;
                    end
                endcase
            end

            // Completion wins over timeout when both land on the same cycle.
            S_WAIT: begin
                if (alu_done) begin
                    zlo_d   = alu_lo;
                    zhi_d   = alu_hi;
                    state_d = S_HOLD;
                end else if (cnt_inc == CNT_LIMIT) begin
                    cnt_d   = cnt_inc;
                    zlo_d   = '0;
                    zhi_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            zlo_q   <= '0;
            zhi_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            zlo_q   <= zlo_d;
            zhi_q   <= zhi_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign alu_a  = a_q;
    assign alu_b  = b_q;
    assign alu_op = op_q;
    assign z_lo   = zlo_q;
    assign z_hi   = zhi_q;
    assign err    = err_q;

endmodule

// File: tb/tb_alu_stage_ctrl.sv
// Scoreboard bench for alu_stage_ctrl with a small behavioural ALU in place of the datapath.
module tb_alu_stage_ctrl;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  op_s = '0;
    logic [31:0] a_s = '0;
    logic [31:0] b_s = '0;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_op;
    logic        alu_start;
    logic        alu_done = 1'b0;
    logic [31:0] alu_lo, alu_hi;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] z_lo, z_hi;
    logic        err;

    typedef struct {
        string       name;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_stage_ctrl dut (
        .clk       (clk),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op_s),
        .a_in      (a_s),
        .b_in      (b_s),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_start (alu_start),
        .alu_done  (alu_done),
        .alu_lo    (alu_lo),
        .alu_hi    (alu_hi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z_lo      (z_lo),
        .z_hi      (z_hi),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: amounts >= 32 produce 0 so the unmasked path is observable.
    logic [63:0] prod, dbl;
    always_comb begin
        alu_lo = '0;
        alu_hi = '0;
        prod   = {32'b0, alu_a} * {32'b0, alu_b};
        dbl    = {alu_a, alu_a} >> alu_b[4:0];
        case (alu_op)
            OP_ADD: alu_lo = alu_a + alu_b;
            OP_ROR: if (alu_b < 32) alu_lo = dbl[31:0];
            OP_MUL: begin
                alu_lo = prod[31:0];
                alu_hi = prod[63:32];
            end
            OP_DIV: if (alu_b != 0) begin
                alu_lo = alu_a / alu_b;
                alu_hi = alu_a % alu_b;
            end
            default: ;
        endcase
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Monitor: one scoreboard entry per completed output handshake.
    always @(negedge clk) begin
        if (!clr && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output actual z_hi=%0h z_lo=%0h err=%0b required none", z_hi, z_lo, err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_z_lo"}, {32'b0, z_lo}, {32'b0, e.lo});
                chk({e.name, "_z_hi"}, {32'b0, z_hi}, {32'b0, e.hi});
                chk({e.name, "_err"},  {63'b0, err},  {63'b0, e.err});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string nm, input logic [31:0] lo, input logic [31:0] hi, input logic e);
        exp_t x;
        x.name = nm;
        x.lo   = lo;
        x.hi   = hi;
        x.err  = e;
        sb.push_back(x);
    endtask

    task automatic accept(input string nm, input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        chk({nm, "_in_ready_pre"}, {63'b0, in_ready}, 64'd1);
        in_valid = 1'b1;
        op_s     = o;
        a_s      = a;
        b_s      = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string nm, input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) tick();
        chk({nm, "_drained"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        logic        bad;
        logic [31:0] ror_b, ror_z;

        repeat (3) tick();
        clr = 1'b0;
        tick();
        chk("rst_in_ready",  {63'b0, in_ready},  64'd1);
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_alu_start", {63'b0, alu_start}, 64'd0);
        chk("rst_err",       {63'b0, err},       64'd0);
        chk("rst_z",         {z_hi, z_lo},       64'd0);
        chk("rst_alu_ab",    {alu_a, alu_b},     64'd0);
        chk("rst_alu_op",    {59'b0, alu_op},    64'd0);

        // ADD 5+7, consumer always ready.
        out_ready = 1'b1;
        push("add", 32'd12, 32'd0, 1'b0);
        accept("add", OP_ADD, 32'd5, 32'd7);
        chk("add_start_issue", {63'b0, alu_start}, 64'd1);
        chk("add_in_ready_busy", {63'b0, in_ready}, 64'd0);
        chk("add_out_valid_issue", {63'b0, out_valid}, 64'd0);
        chk("add_alu_ab", {alu_a, alu_b}, {32'd5, 32'd7});
        tick();
        chk("add_out_valid_e1", {63'b0, out_valid}, 64'd1);
        chk("add_start_e1", {63'b0, alu_start}, 64'd0);
        wait_drain("add", 10);

        // MUL completing 10 cycles after ISSUE, consumer stalls 3 cycles.
        out_ready = 1'b0;
        push("mul", 32'd0, 32'd2, 1'b0);
        accept("mul", OP_MUL, 32'h8000_0000, 32'd4);
        chk("mul_start_issue", {63'b0, alu_start}, 64'd1);
        bad = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (out_valid || in_ready || alu_start) bad = 1'b1;
        end
        chk("mul_busy_wait", {63'b0, bad}, 64'd0);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        chk("mul_out_valid_e10", {63'b0, out_valid}, 64'd1);
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (!out_valid || in_ready || z_hi != 32'd2 || z_lo != 32'd0) bad = 1'b1;
        end
        chk("mul_hold_stable", {63'b0, bad}, 64'd0);
        out_ready = 1'b1;
        wait_drain("mul", 10);

        // DIV that never completes: timeout after 64 WAIT cycles.
        push("div_timeout", 32'd0, 32'd0, 1'b1);
        accept("div", OP_DIV, 32'd100, 32'd7);
        n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        chk("div_timeout_latency", 64'(n), 64'd65);
        wait_drain("div", 10);

        // Illegal opcode: no start, error result one cycle later.
        push("illegal", 32'd0, 32'd0, 1'b1);
        accept("illegal", 5'b10101, 32'd3, 32'd4);
        chk("illegal_no_start", {63'b0, alu_start}, 64'd0);
        tick();
        chk("illegal_out_valid_e1", {63'b0, out_valid}, 64'd1);
        wait_drain("illegal", 10);

        // ROR by 33.
`ifdef ROT_AMOUNT_MASK_EN
        ror_b = 32'd1;
        ror_z = 32'h8000_0000;
`else
        ror_b = 32'd33;
        ror_z = 32'd0;
`endif
        push("ror", ror_z, 32'd0, 1'b0);
        accept("ror", OP_ROR, 32'h0000_0001, 32'd33);
        chk("ror_alu_b", {32'b0, alu_b}, {32'b0, ror_b});
        wait_drain("ror", 10);

        // Reset mid-WAIT abandons the MUL; a stray alu_done afterwards is ignored.
        accept("clr_mul", OP_MUL, 32'd6, 32'd7);
        repeat (5) tick();
        clr = 1'b1;
        #2;
        chk("clr_async_out_valid", {63'b0, out_valid}, 64'd0);
        clr = 1'b0;
        #1;
        chk("clr_in_ready",  {63'b0, in_ready},  64'd1);
        chk("clr_ctrl",      {61'b0, alu_start, err, out_valid}, 64'd0);
        chk("clr_z",         {z_hi, z_lo},       64'd0);
        chk("clr_alu_ab",    {alu_a, alu_b},     64'd0);
        chk("clr_alu_op",    {59'b0, alu_op},    64'd0);
        tick();
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        chk("stray_done_out_valid", {63'b0, out_valid}, 64'd0);
        push("post_clr_add", 32'd2, 32'd0, 1'b0);
        accept("post_clr_add", OP_ADD, 32'd1, 32'd1);
        wait_drain("post_clr_add", 10);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_stage_ctrl.md
# alu_stage_ctrl

Operand staging and result capture stage that wraps the 32-bit ALU datapath (add/sub/logic/shift/rotate, multi-cycle mul/div). Accepts an opcode and two operands over a valid/ready handshake, presents stable operands to the ALU, pulses a start strobe, and captures the 64-bit result into the Z register pair (z_hi/z_lo). Its output handshake feeds the register-file write-back path.

## Interface
- WIDTH, 32, operand and result-half width
- MAX_WAIT, 64, maximum cycles to wait for alu_done on multi-cycle ops
- clk  in  1  clock; all state changes on rising edge
- clr  in  1  asynchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  stage can accept a request
- op  in  5  ALU opcode
- a_in, b_in  in  WIDTH  operands
- alu_a, alu_b  out  WIDTH  operands to ALU, held stable from ISSUE through capture
- alu_op  out  5  opcode to ALU
- alu_start  out  1  one-cycle start strobe
- alu_done  in  1  multi-cycle op complete (ignored for single-cycle ops)
- alu_lo, alu_hi  in  WIDTH  ALU result halves
- out_valid  out  1  Z holds a result
- out_ready  in  1  consumer takes result
- z_lo, z_hi  out  WIDTH  captured result
- err  out  1  illegal opcode or timeout on current result

## Operation
- FSM: IDLE, ISSUE, WAIT, HOLD.
- IDLE: in_ready=1. On in_valid: latch op, a_in, b_in; -> ISSUE.
- ISSUE (one cycle): alu_start=1. Single-cycle op: capture alu_lo/alu_hi into Z at end of cycle -> HOLD. Multi-cycle op: if alu_done=1 this cycle capture -> HOLD, else -> WAIT.
- WAIT: wait counter increments each cycle; capture on alu_done -> HOLD. If counter reaches MAX_WAIT with no alu_done: Z=0, err=1 -> HOLD.
- HOLD: out_valid=1, Z and err stable; on out_ready -> IDLE. in_ready=0 in every state except IDLE.
- Opcode classes: MUL=5'b01111, DIV=5'b10000 multi-cycle; 5'b00000..5'b01110 single-cycle; 5'b10001..5'b11111 illegal: no alu_start, Z=0, err=1, ISSUE -> HOLD.
- Single-cycle ops: z_hi = alu_hi as driven (0 for logic/shift/rotate).
- Counter width: clog2(MAX_WAIT+1); cleared on entry to ISSUE.

## Timing
- Reset (clr=1, any state, any time): state IDLE; in_ready=1 after release; alu_start, out_valid, err = 0; z_lo, z_hi, alu_a, alu_b = 0; alu_op=0; counter=0. An in-flight multi-cycle op is abandoned; a later alu_done in IDLE is ignored.
- Single-cycle latency: accept at edge E0; ISSUE during E0–E1; out_valid=1 from E1.
- Multi-cycle: out_valid=1 from the edge on which alu_done=1 is sampled.
- alu_done sampled high in IDLE or HOLD: ignored.
- out_valid and out_ready both high at edge E: IDLE from E; earliest next accept at E+1. No same-edge accept.
- alu_a/alu_b/alu_op change only on accept edges.

## Configuration
- ROT_AMOUNT_MASK_EN defined: for ROR (5'b00111), ROL (5'b01000), SHR, SHRA, SHL (5'b01001..5'b01011), alu_b = {0, b_in[4:0]} (amount modulo 32; amount 0 yields A unchanged).
- Not defined: alu_b = b_in unmodified; the ALU's behaviour for amounts >= 32 is passed through.

## Structure
- Shared package alu_pkg: opcode localparams (ADD..DIV), op-class enum (SINGLE, MULTI, ILLEGAL), FSM state typedef.
- One sub-module: alu_op_class, combinational opcode -> class decoder, reused by the control unit.

## Test plan
- ADD, a_in=5, b_in=7, out_ready=1 -> out_valid from E1, z_lo=12, z_hi=0, err=0, alu_start high exactly one cycle.
- ROR, a_in=32'h0000_0001, b_in=33 with ROT_AMOUNT_MASK_EN -> alu_b=1, z_lo=32'h8000_0000; without macro -> alu_b=33.
- MUL with alu_done after 10 cycles, out_ready=0 for 3 cycles -> out_valid 10 cycles after ISSUE; Z holds until out_ready; in_ready=0 throughout.
- DIV with alu_done never asserted, MAX_WAIT=64 -> err=1, z_hi=z_lo=0 after 64 WAIT cycles.
- Opcode 5'b10101 -> no alu_start, out_valid after E1 with err=1, Z=0.
- clr pulsed mid-WAIT, then alu_done=1 -> all outputs 0, state IDLE, stray alu_done ignored; next ADD 1+1 -> z_lo=2.
